spi_rx_deser: RTL and testbench
===============================

Name: spi_rx_deser

Overview:
- Parametrised SPI receive deserialiser; next generation of the MOSI shift-in register.
- Operates in the system clk domain on pre-synchronised sclk/cs_n/mosi and detects SCLK edges internally.
- Supports all four CPOL/CPHA modes, MSB- or LSB-first ordering, and back-to-back words within one chip-select.
- Buffers completed words in a small FIFO with a valid/ready output, plus framing-error and overrun reporting.

Parameters:
- DATA_WIDTH, 8, bits per word (2..32).
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2).
- CNT_W, $clog2(DATA_WIDTH), bit-counter width (derived, not overridden).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- en  in  1  block enable; when low, no frame starts and sample edges are ignored
- cpol  in  1  clock polarity; latched on cs_n falling edge
- cpha  in  1  clock phase; latched on cs_n falling edge
- lsb_first  in  1  bit order; latched on cs_n falling edge
- sclk  in  1  SPI clock, already synchronised to clk
- cs_n  in  1  chip select, active-low, already synchronised
- mosi  in  1  serial data, already synchronised
- out_data  out  DATA_WIDTH  FIFO head word (first-word fall-through)
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- busy  out  1  high in SHIFT state
- frame_err  out  1  one-cycle pulse on a partial word at cs_n rise
- overrun  out  1  sticky; word dropped because the FIFO was full
- ovr_clr  in  1  synchronous clear of overrun

Behaviour:
- Reset (rst=0, async): state IDLE, shift reg 0, bit count 0, FIFO empty, out_data 0, out_valid 0, fifo_level 0, busy 0, frame_err 0, overrun 0, latched mode 0.
- Edge detect: sclk_d is sclk registered. rise = sclk & ~sclk_d; fall = ~sclk & sclk_d.
- Sample edge: rise when cpol==cpha, otherwise fall (latched mode values).
- cs_n falling edge is detected on registered cs_n.
- IDLE -> SHIFT: on cs_n fall with en=1. Latch cpol/cpha/lsb_first; clear count and shift reg.
- SHIFT, on each sample edge:
  - MSB-first: shift reg = {sr[W-2:0], mosi}.
  - LSB-first: shift reg = {mosi, sr[W-1:1]}.
  - count increments.
- Word complete: sample edge with count==DATA_WIDTH-1.
  - The assembled word, including the current bit, is pushed to the FIFO on that same clk edge.
  - count returns to 0; state stays SHIFT so back-to-back words continue.
  - out_valid rises 1 clk after that edge if the FIFO was empty.
- SHIFT -> IDLE: on cs_n high.
  - If count!=0, frame_err pulses for exactly 1 cycle and the partial word is discarded (no push).
  - count==0 gives no error.
- en low in SHIFT: sample edges are ignored; the current count is held.
- FIFO push when full: the word is dropped and overrun is set.
  - Exception: a pop in the same cycle frees a slot, so the push is accepted and no overrun occurs.
- Push and pop on an empty FIFO in the same cycle: only the push takes effect; out_valid rises next cycle.
- overrun clears when ovr_clr=1 unless a new overrun occurs in the same cycle; set wins.
- Pop: out_valid && out_ready; fifo_level decrements; pointers wrap modulo FIFO_DEPTH.
- Async reset mid-frame discards all state and FIFO contents immediately.

Optional Feature:
- SPI_RX_OVR_CNT_EN defined: adds output ovr_count[7:0].
  - Counts dropped words and saturates at 255.
  - Cleared by reset or ovr_clr; increments even when the same cycle asserts ovr_clr.
- Not defined: port and counter are absent; overrun flag only.

Decomposition:
- Package spi_pkg:
  - mode encoding constants SPI_MODE0..3 as {cpol,cpha};
  - state typedef (IDLE, SHIFT);
  - default DATA_WIDTH/FIFO_DEPTH localparams.
- Sub-module spi_rx_fifo:
  - synchronous FWFT FIFO, parameters WIDTH and DEPTH;
  - ports push/din/full/pop/dout/empty/level;
  - the deserialiser instantiates one.

Test Plan:
- Mode 0, MSB-first, send 0xA5 under one cs_n -> out_valid 1 clk after 8th rising edge, out_data=0xA5, fifo_level=1.
- Mode 3, LSB-first, send 0x3C then 0x81 in one cs_n -> two words 0x3C, 0x81 in order, frame_err never asserted.
- cs_n rises after 3 bits -> frame_err 1-cycle pulse, fifo_level unchanged, next frame decodes 0x5A correctly.
- FIFO_DEPTH=4, out_ready=0, send 5 words -> level 4, overrun=1, 5th word lost. With SPI_RX_OVR_CNT_EN, ovr_count=1. Pop 4 words -> first 4 words intact.
- FIFO full, pop coincident with 5th push -> no overrun, level remains 4.
- rst asserted after 4 bits -> all outputs at reset values. Next full frame of 0xC3 -> 0xC3 received.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI receive deserialiser: default sizes,
// {cpol,cpha} mode encodings and the receive FSM state type.
package spi_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/spi_rx_deser_if.sv
// Output word stream of the SPI receive deserialiser.
// Handshake: a word transfers on a clk edge where out_valid && out_ready; out_data
// is stable while out_valid is high and not yet accepted; out_valid never depends on out_ready.
interface spi_rx_deser_if
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [LVL_W-1:0]      fifo_level;

  modport master (
    output out_data,
    output out_valid,
    output fifo_level,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  fifo_level,
    output out_ready
  );

endinterface

// File: rtl/spi_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; a pop frees a slot for a push in
// the same cycle, and a push+pop on an empty FIFO keeps only the push.
module spi_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [LW-1:0]    r_lvl;
  logic             w_pop;
  logic             w_push;

  assign empty  = (r_lvl == '0);
  assign full   = (r_lvl == LW'(DEPTH));
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  assign level  = r_lvl;
  // Head reads as zero while empty so reset and drained states look identical.
  assign dout   = empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_lvl <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_lvl <= r_lvl + LW'(1);
        2'b01:   r_lvl <= r_lvl - LW'(1);
        default: r_lvl <= r_lvl;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

endmodule

// File: rtl/spi_rx_deser.sv
// SPI receive deserialiser: samples pre-synchronised sclk/cs_n/mosi in the clk
// domain and buffers words in a FIFO. Optional SPI_RX_OVR_CNT_EN adds ovr_count.
module spi_rx_deser
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  logic   cpol,
  input  logic   cpha,
  input  logic   lsb_first,
  input  logic   sclk,
  input  logic   cs_n,
  input  logic   mosi,
  spi_rx_deser_if.master rx_bus,
  output logic   busy,
  output logic   frame_err,
  output logic   overrun,
  input  logic   ovr_clr,
`ifdef SPI_RX_OVR_CNT_EN
  output logic [7:0] ovr_count,
`endif
  output state_t dbg_state
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_sr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_cpol;
  logic                  r_cpha;
  logic                  r_lsb;
  logic                  r_busy;
  logic                  r_frame_err;
  logic                  r_overrun;
  logic                  r_sclk_d;
  logic                  r_cs_n_d;

  logic                  w_rise;
  logic                  w_fall;
  logic                  w_sample;
  logic                  w_cs_fall;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_sr_next;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_drop;
  logic [DATA_WIDTH-1:0] w_dout;
  logic [LVL_W-1:0]      w_level;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_d <= 1'b0;
      r_cs_n_d <= 1'b1;
    end else begin
      r_sclk_d <= sclk;
      r_cs_n_d <= cs_n;
    end
  end

  assign w_rise    = sclk & ~r_sclk_d;
  assign w_fall    = ~sclk & r_sclk_d;
  assign w_cs_fall = ~cs_n & r_cs_n_d;

  // Modes 0 and 3 sample on the rising SCLK edge, modes 1 and 2 on the falling one.
  always_comb begin
    w_sample = 1'b0;
    case ({r_cpol, r_cpha})
      SPI_MODE0, SPI_MODE3: w_sample = w_rise;
      SPI_MODE1, SPI_MODE2: w_sample = w_fall;
      default:              w_sample = 1'b0;
    endcase
  end

  assign w_sr_next = r_lsb ? {mosi, r_sr[DATA_WIDTH-1:1]}
                           : {r_sr[DATA_WIDTH-2:0], mosi};
  assign w_last    = (r_cnt == CNT_W'(DATA_WIDTH - 1));
  assign w_push    = (r_state == ST_SHIFT) & ~cs_n & en & w_sample & w_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_sr        <= '0;
      r_cnt       <= '0;
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
      r_lsb       <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall && en) begin
            r_state <= ST_SHIFT;
            r_busy  <= 1'b1;
            r_cpol  <= cpol;
            r_cpha  <= cpha;
            r_lsb   <= lsb_first;
            r_cnt   <= '0;
            r_sr    <= '0;
          end
        end
        ST_SHIFT: begin
          if (cs_n) begin
            // A deselect mid-word drops the partial word and flags it once.
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_frame_err <= (r_cnt != '0);
          end else if (w_sample && en) begin
            r_sr  <= w_sr_next;
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign w_pop  = ~w_empty & rx_bus.out_ready;
  assign w_drop = w_push & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (ovr_clr) begin
      r_overrun <= 1'b0;
    end
  end

`ifdef SPI_RX_OVR_CNT_EN
  logic [7:0] r_ovr_count;

  // A drop in the same cycle as a clear leaves the count at one, not zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovr_count <= 8'd0;
    end else if (w_drop) begin
      if (ovr_clr)                  r_ovr_count <= 8'd1;
      else if (r_ovr_count != 8'hFF) r_ovr_count <= r_ovr_count + 8'd1;
    end else if (ovr_clr) begin
      r_ovr_count <= 8'd0;
    end
  end

  assign ovr_count = r_ovr_count;
`endif

  spi_rx_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (w_sr_next),
    .full  (w_full),
    .pop   (w_pop),
    .dout  (w_dout),
    .empty (w_empty),
    .level (w_level)
  );

  assign rx_bus.out_data   = w_dout;
  assign rx_bus.out_valid  = ~w_empty;
  assign rx_bus.fifo_level = w_level;
  assign busy              = r_busy;
  assign frame_err         = r_frame_err;
  assign overrun           = r_overrun;
  assign dbg_state         = r_state;

endmodule

// File: tb/tb_spi_rx_deser.sv
// Directed and randomized bench for spi_rx_deser, checked against a queue-based
// word model; honours SPI_RX_OVR_CNT_EN for the drop counter.
module tb_spi_rx_deser;
  import spi_pkg::*;

  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0, cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0, ovr_clr = 1'b0;
  logic busy, frame_err, overrun;
  state_t dbg_state;
`ifdef SPI_RX_OVR_CNT_EN
  logic [7:0] ovr_count;
`endif

  spi_rx_deser_if #(.DATA_WIDTH(W), .FIFO_DEPTH(D)) rx_bus ();

  spi_rx_deser #(.DATA_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cpol      (cpol),
    .cpha      (cpha),
    .lsb_first (lsb_first),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .rx_bus    (rx_bus),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr),
`ifdef SPI_RX_OVR_CNT_EN
    .ovr_count (ovr_count),
`endif
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int fe_cnt = 0;

  logic [W-1:0] exp_q[$];
  bit m_ovr = 1'b0;
  int m_ovr_cnt = 0;

  always @(negedge clk) if (frame_err === 1'b1) fe_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Model of word completion: queued if there is room, otherwise counted as dropped.
  task automatic model_word(input logic [W-1:0] w);
    if (exp_q.size() < D) exp_q.push_back(w);
    else begin
      m_ovr = 1'b1;
      if (m_ovr_cnt < 255) m_ovr_cnt++;
    end
  endtask

  task automatic frame_begin(input bit pol, input bit pha, input bit lsb);
    cpol = pol; cpha = pha; lsb_first = lsb;
    sclk = pol; cs_n = 1'b1;
    tick(); tick();
    cs_n = 1'b0;
    tick(); tick();
  endtask

  task automatic frame_end();
    cs_n = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic spi_bit(input logic b);
    mosi = b;
    tick();
    sclk = ~sclk;
    tick(); tick();
    sclk = ~sclk;
    tick(); tick();
  endtask

  function automatic logic bit_at(input logic [W-1:0] w, input int i);
    return lsb_first ? w[i] : w[W-1-i];
  endfunction

  task automatic send_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) spi_bit(bit_at(w, i));
    model_word(w);
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_level"}, 32'(rx_bus.fifo_level), 32'(exp_q.size()));
    chk({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
`ifdef SPI_RX_OVR_CNT_EN
    chk({tag, "_ovrcnt"}, 32'(ovr_count), 32'(m_ovr_cnt));
`endif
  endtask

  task automatic drain(input string tag);
    int n;
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      chk({tag, "_valid"}, 32'(rx_bus.out_valid), 32'd1);
      chk({tag, "_data"}, 32'(rx_bus.out_data), 32'(exp_q.pop_front()));
      rx_bus.out_ready = 1'b1;
      tick();
      rx_bus.out_ready = 1'b0;
    end
    chk({tag, "_empty_valid"}, 32'(rx_bus.out_valid), 32'd0);
    chk({tag, "_empty_level"}, 32'(rx_bus.fifo_level), 32'd0);
  endtask

  task automatic clear_ovr();
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    m_ovr = 1'b0;
    m_ovr_cnt = 0;
  endtask

  initial begin
    int fe0;
    logic [W-1:0] w;
    logic [W-1:0] w5;
    int nw;

    rx_bus.out_ready = 1'b0;
    rst = 1'b0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(rx_bus.out_valid), 32'd0);
    chk("rst_level", 32'(rx_bus.fifo_level), 32'd0);
    chk("rst_data", 32'(rx_bus.out_data), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
`ifdef SPI_RX_OVR_CNT_EN
    chk("rst_ovrcnt", 32'(ovr_count), 32'd0);
`endif
    rst = 1'b1;
    en = 1'b1;
    tick(); tick();

    // Mode 0 MSB-first 0xA5, checking the cycle the word appears.
    fe0 = fe_cnt;
    w = 8'hA5;
    frame_begin(1'b0, 1'b0, 1'b0);
    chk("t1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < W - 1; i++) spi_bit(bit_at(w, i));
    mosi = bit_at(w, W - 1);
    tick();
    sclk = 1'b1;
    chk("t1_valid_before", 32'(rx_bus.out_valid), 32'd0);
    tick();
    chk("t1_valid_after", 32'(rx_bus.out_valid), 32'd1);
    chk("t1_data", 32'(rx_bus.out_data), 32'hA5);
    chk("t1_level", 32'(rx_bus.fifo_level), 32'd1);
    tick();
    sclk = 1'b0;
    tick(); tick();
    exp_q.push_back(w);
    frame_end();
    chk("t1_noferr", 32'(fe_cnt), 32'(fe0));
    drain("t1");

    // Mode 3 LSB-first, two back-to-back words in one select.
    fe0 = fe_cnt;
    frame_begin(1'b1, 1'b1, 1'b1);
    send_word(8'h3C);
    send_word(8'h81);
    frame_end();
    chk("t2_noferr", 32'(fe_cnt), 32'(fe0));
    check_status("t2");
    drain("t2");

    // Partial word of 3 bits, then a clean frame.
    frame_begin(1'b0, 1'b0, 1'b0);
    spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1);
    cs_n = 1'b1;
    tick();
    chk("t3_ferr_pulse", 32'(frame_err), 32'd1);
    tick();
    chk("t3_ferr_end", 32'(frame_err), 32'd0);
    chk("t3_level", 32'(rx_bus.fifo_level), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    frame_begin(1'b0, 1'b0, 1'b0);
    send_word(8'h5A);
    frame_end();
    check_status("t3");
    drain("t3");

    // Sample edges with en low are ignored and the count is held.
    w = 8'h96;
    frame_begin(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) spi_bit(bit_at(w, i));
    en = 1'b0;
    spi_bit(1'b1); spi_bit(1'b1);
    chk("t4_busy_hold", 32'(busy), 32'd1);
    en = 1'b1;
    for (int i = 3; i < W; i++) spi_bit(bit_at(w, i));
    model_word(w);
    fe0 = fe_cnt;
    frame_end();
    chk("t4_noferr", 32'(fe_cnt), 32'(fe0));
    drain("t4");

    // Five words into a four-entry FIFO with no consumer.
    frame_begin(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) send_word(W'($urandom_range(0, 255)));
    frame_end();
    chk("t5_full", 32'(rx_bus.fifo_level), 32'd4);
    chk("t5_ovr_set", 32'(overrun), 32'd1);
    check_status("t5");
    drain("t5");
    clear_ovr();
    chk("t5_ovr_clr", 32'(overrun), 32'd0);

    // Full FIFO with a pop on the same edge as the fifth push.
    frame_begin(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) send_word(W'($urandom_range(0, 255)));
    w5 = W'($urandom_range(0, 255));
    for (int i = 0; i < W - 1; i++) spi_bit(bit_at(w5, i));
    mosi = bit_at(w5, W - 1);
    tick();
    sclk = 1'b1;
    rx_bus.out_ready = 1'b1;
    chk("t6_head", 32'(rx_bus.out_data), 32'(exp_q[0]));
    tick();
    rx_bus.out_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(w5);
    chk("t6_level", 32'(rx_bus.fifo_level), 32'd4);
    chk("t6_no_ovr", 32'(overrun), 32'd0);
    tick();
    sclk = 1'b0;
    tick(); tick();
    frame_end();
    check_status("t6");
    drain("t6");

    // Asynchronous reset in the middle of a frame with data buffered.
    frame_begin(1'b0, 1'b0, 1'b0);
    send_word(8'h77);
    for (int i = 0; i < 4; i++) spi_bit(1'b1);
    rst = 1'b0;
    #2;
    chk("t7_busy", 32'(busy), 32'd0);
    chk("t7_valid", 32'(rx_bus.out_valid), 32'd0);
    chk("t7_level", 32'(rx_bus.fifo_level), 32'd0);
    chk("t7_data", 32'(rx_bus.out_data), 32'd0);
    chk("t7_state", 32'(dbg_state), 32'(ST_IDLE));
    exp_q.delete();
    m_ovr = 1'b0;
    m_ovr_cnt = 0;
    cs_n = 1'b1;
    sclk = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    frame_begin(1'b0, 1'b0, 1'b0);
    send_word(8'hC3);
    frame_end();
    check_status("t7");
    drain("t7");

    // Randomized frames across all modes and bit orders.
    for (int f = 0; f < 20; f++) begin
      fe0 = fe_cnt;
      frame_begin(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      nw = $urandom_range(1, 3);
      for (int k = 0; k < nw; k++) send_word(W'($urandom_range(0, 255)));
      frame_end();
      chk("rnd_noferr", 32'(fe_cnt), 32'(fe0));
      check_status("rnd");
      if ($urandom_range(0, 1) == 1) drain("rnd");
      if (m_ovr) begin
        clear_ovr();
        chk("rnd_ovr_clr", 32'(overrun), 32'd0);
      end
    end
    drain("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
